// File: rtl/l2_read_arbiter.sv
// l2_read_arbiter: shares one L2 read request/response port among icache refill,
// dcache miss-read and dcache uncached-read. Requests are round-robin arbitrated into a
// one-entry registered slot and tagged with a 2-bit source ID; responses are routed back
// combinationally by that tag. Per-source outstanding limits gate eligibility.
module l2_read_arbiter #(
  parameter int unsigned ADDR_W    = 40,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned DC_ID_W   = 4,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  // icache refill
  input  logic                 ic_req_valid_i,
  input  logic [ADDR_W-1:0]    ic_req_addr_i,
  output logic                 ic_resp_valid_o,
  output logic [DATA_W-1:0]    ic_resp_data_o,
  // dcache miss-read
  input  logic                 mr_req_valid_i,
  output logic                 mr_req_ready_o,
  input  logic [ADDR_W-1:0]    mr_req_addr_i,
  input  logic [7:0]           mr_req_len_i,
  input  logic [2:0]           mr_req_size_i,
  input  logic [DC_ID_W-1:0]   mr_req_id_i,
  output logic                 mr_resp_valid_o,
  input  logic                 mr_resp_ready_i,
  output logic [DATA_W-1:0]    mr_resp_data_o,
  output logic [DC_ID_W-1:0]   mr_resp_id_o,
  output logic                 mr_resp_last_o,
  // dcache uncached-read
  input  logic                 uc_req_valid_i,
  output logic                 uc_req_ready_o,
  input  logic [ADDR_W-1:0]    uc_req_addr_i,
  input  logic [7:0]           uc_req_len_i,
  input  logic [2:0]           uc_req_size_i,
  input  logic [DC_ID_W-1:0]   uc_req_id_i,
  output logic                 uc_resp_valid_o,
  input  logic                 uc_resp_ready_i,
  output logic [DATA_W-1:0]    uc_resp_data_o,
  output logic [DC_ID_W-1:0]   uc_resp_id_o,
  output logic                 uc_resp_last_o,
  // downstream L2 port
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [ADDR_W-1:0]    req_addr_o,
  output logic [7:0]           req_len_o,
  output logic [2:0]           req_size_o,
  output logic [DC_ID_W+1:0]   req_id_o,
  input  logic                 resp_valid_i,
  output logic                 resp_ready_o,
  input  logic [DATA_W-1:0]    resp_data_i,
  input  logic [DC_ID_W+1:0]   resp_id_i,
  input  logic                 resp_last_i,
  // sticky errors
  output logic                 err_ic_overrun_o,
  output logic                 err_bad_id_o
);

  localparam int unsigned CntW   = $clog2(MAX_OUTST + 1);
  localparam int unsigned IdW    = DC_ID_W + 2;
  localparam logic [2:0]  IcSize = 3'($clog2(DATA_W / 8));
  localparam logic [1:0]  TagIc  = 2'b00;
  localparam logic [1:0]  TagMr  = 2'b01;
  localparam logic [1:0]  TagUc  = 2'b10;
  localparam logic [1:0]  TagBad = 2'b11;

  function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] cnt, input logic inc,
                                               input logic dec);
    logic [CntW-1:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + CntW'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      res = cnt - CntW'(1);
    end
    return res;
  endfunction

  // active_q holds response/handshake outputs at zero while in reset and until the first
  // clock edge after release.
  logic                active_q;
  logic                ic_pend_q, ic_pend_d;
  logic [ADDR_W-1:0]   ic_addr_q, ic_addr_d;
  logic                ic_outst_q, ic_outst_d;
  logic [CntW-1:0]     mr_outst_q, mr_outst_d, uc_outst_q, uc_outst_d;
  logic [1:0]          prio_q, prio_d;
  logic                slot_valid_q, slot_valid_d;
  logic [ADDR_W-1:0]   slot_addr_q, slot_addr_d;
  logic [7:0]          slot_len_q, slot_len_d;
  logic [2:0]          slot_size_q, slot_size_d;
  logic [IdW-1:0]      slot_id_q, slot_id_d;
  logic                err_ov_q, err_ov_d, err_bad_q, err_bad_d;

  logic [2:0] elig;
  logic [1:0] win, idx;
  logic       any_elig, slot_free, grant, grant_ic, grant_mr, grant_uc, ic_busy;
  logic [1:0] resp_tag;
  logic       resp_hs, ic_dec, mr_dec, uc_dec;

  assign slot_free = !slot_valid_q || req_ready_i;
  assign ic_busy   = ic_pend_q || ic_outst_q;
  assign elig[0]   = ic_pend_q && !ic_outst_q;
  assign elig[1]   = mr_req_valid_i && (mr_outst_q < CntW'(MAX_OUTST));
  assign elig[2]   = uc_req_valid_i && (uc_outst_q < CntW'(MAX_OUTST));

  // Round-robin pick: smallest offset from prio_q wins, so scan from the far end down.
  always_comb begin
    win      = TagIc;
    idx      = 2'd0;
    any_elig = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      idx = 2'((int'(prio_q) + k) % 3);
      if (elig[idx]) begin
        win      = idx;
        any_elig = 1'b1;
      end
    end
  end

  assign grant          = active_q && slot_free && any_elig;
  assign grant_ic       = grant && (win == TagIc);
  assign grant_mr       = grant && (win == TagMr);
  assign grant_uc       = grant && (win == TagUc);
  assign mr_req_ready_o = grant_mr;
  assign uc_req_ready_o = grant_uc;

  assign resp_tag = resp_id_i[IdW-1:DC_ID_W];

  // Route the downstream response to its source by tag; bad tags are sunk.
  always_comb begin
    ic_resp_valid_o = 1'b0;
    mr_resp_valid_o = 1'b0;
    uc_resp_valid_o = 1'b0;
    resp_ready_o    = 1'b0;
    if (active_q) begin
      unique case (resp_tag)
        TagIc: begin
          ic_resp_valid_o = resp_valid_i;
          resp_ready_o    = 1'b1;
        end
        TagMr: begin
          mr_resp_valid_o = resp_valid_i;
          resp_ready_o    = mr_resp_ready_i;
        end
        TagUc: begin
          uc_resp_valid_o = resp_valid_i;
          resp_ready_o    = uc_resp_ready_i;
        end
        default: resp_ready_o = 1'b1;
      endcase
    end
  end

  assign ic_resp_data_o = active_q ? resp_data_i : '0;
  assign mr_resp_data_o = active_q ? resp_data_i : '0;
  assign uc_resp_data_o = active_q ? resp_data_i : '0;
  assign mr_resp_id_o   = active_q ? resp_id_i[DC_ID_W-1:0] : '0;
  assign uc_resp_id_o   = active_q ? resp_id_i[DC_ID_W-1:0] : '0;
  assign mr_resp_last_o = active_q && resp_last_i;
  assign uc_resp_last_o = active_q && resp_last_i;

  assign resp_hs = resp_valid_i && resp_ready_o;
  assign ic_dec  = resp_hs && resp_last_i && (resp_tag == TagIc);
  assign mr_dec  = resp_hs && resp_last_i && (resp_tag == TagMr);
  assign uc_dec  = resp_hs && resp_last_i && (resp_tag == TagUc);

  // Icache capture register and sticky error flags.
  always_comb begin
    ic_pend_d = ic_pend_q;
    ic_addr_d = ic_addr_q;
    err_ov_d  = err_ov_q;
    err_bad_d = err_bad_q | (resp_hs && (resp_tag == TagBad));
    if (grant_ic) begin
      ic_pend_d = 1'b0;
    end
    // A pulse is judged against the pre-grant state, so one landing on the clearing grant
    // is still an overrun.
    if (ic_req_valid_i) begin
      if (ic_busy) begin
        err_ov_d = 1'b1;
      end else begin
        ic_pend_d = 1'b1;
        ic_addr_d = ic_req_addr_i;
      end
    end
  end

  // Outstanding counters: up on grant, down on last-beat response handshake.
  always_comb begin
    ic_outst_d = ic_outst_q;
    if (grant_ic && !ic_dec) begin
      ic_outst_d = 1'b1;
    end else if (ic_dec && !grant_ic) begin
      ic_outst_d = 1'b0;
    end
    mr_outst_d = cnt_next(mr_outst_q, grant_mr, mr_dec);
    uc_outst_d = cnt_next(uc_outst_q, grant_uc, uc_dec);
  end

  // Request slot load/drain and round-robin pointer advance.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_addr_d  = slot_addr_q;
    slot_len_d   = slot_len_q;
    slot_size_d  = slot_size_q;
    slot_id_d    = slot_id_q;
    prio_d       = prio_q;
    if (grant) begin
      slot_valid_d = 1'b1;
      prio_d       = (win == 2'd2) ? 2'd0 : win + 2'd1;
      unique case (win)
        TagMr: begin
          slot_addr_d = mr_req_addr_i;
          slot_len_d  = mr_req_len_i;
          slot_size_d = mr_req_size_i;
          slot_id_d   = {TagMr, mr_req_id_i};
        end
        TagUc: begin
          slot_addr_d = uc_req_addr_i;
          slot_len_d  = uc_req_len_i;
          slot_size_d = uc_req_size_i;
          slot_id_d   = {TagUc, uc_req_id_i};
        end
        default: begin
          slot_addr_d = ic_addr_q;
          slot_len_d  = 8'd0;
          slot_size_d = IcSize;
          slot_id_d   = {TagIc, {DC_ID_W{1'b0}}};
        end
      endcase
    end else if (req_ready_i) begin
      slot_valid_d = 1'b0;
    end
  end

  assign req_valid_o      = slot_valid_q;
  assign req_addr_o       = slot_addr_q;
  assign req_len_o        = slot_len_q;
  assign req_size_o       = slot_size_q;
  assign req_id_o         = slot_id_q;
  assign err_ic_overrun_o = err_ov_q;
  assign err_bad_id_o     = err_bad_q;

  // State registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      active_q     <= 1'b0;
      ic_pend_q    <= 1'b0;
      ic_addr_q    <= '0;
      ic_outst_q   <= 1'b0;
      mr_outst_q   <= '0;
      uc_outst_q   <= '0;
      prio_q       <= TagIc;
      slot_valid_q <= 1'b0;
      slot_addr_q  <= '0;
      slot_len_q   <= '0;
      slot_size_q  <= '0;
      slot_id_q    <= '0;
      err_ov_q     <= 1'b0;
      err_bad_q    <= 1'b0;
    end else begin
      active_q     <= 1'b1;
      ic_pend_q    <= ic_pend_d;
      ic_addr_q    <= ic_addr_d;
      ic_outst_q   <= ic_outst_d;
      mr_outst_q   <= mr_outst_d;
      uc_outst_q   <= uc_outst_d;
      prio_q       <= prio_d;
      slot_valid_q <= slot_valid_d;
      slot_addr_q  <= slot_addr_d;
      slot_len_q   <= slot_len_d;
      slot_size_q  <= slot_size_d;
      slot_id_q    <= slot_id_d;
      err_ov_q     <= err_ov_d;
      err_bad_q    <= err_bad_d;
    end
  end

endmodule
